// File: rtl/seq_pattern_gen_if.sv
// Handshake/bus bundle for seq_pattern_gen.
//   master : controller side (drives start/pattern[/repeat_cnt], observes stream)
//   slave  : generator side
// repeat_cnt is the "repeat" frame count; it exists only when
// SEQ_GEN_REPEAT_EN is defined ("repeat" itself is a reserved word).
interface seq_pattern_gen_if #(
  parameter int PATTERN_LEN = 7,
  parameter int REPEAT_W    = 4
);
  logic                   start;
  logic [PATTERN_LEN-1:0] pattern;
`ifdef SEQ_GEN_REPEAT_EN
  logic [REPEAT_W-1:0]    repeat_cnt;
`endif
  logic                   out;
  logic                   out_valid;
  logic                   busy;
  logic                   done;

`ifdef SEQ_GEN_REPEAT_EN
  modport master (output start, pattern, repeat_cnt, input out, out_valid, busy, done);
  modport slave  (input start, pattern, repeat_cnt, output out, out_valid, busy, done);
`else
  modport master (output start, pattern, input out, out_valid, busy, done);
  modport slave  (input start, pattern, output out, out_valid, busy, done);
`endif
endinterface

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial frame generator.
// Captures a PATTERN_LEN-bit word on an accepted start and shifts it out
// MSB-first, one bit per clock, then pulses done for one (idle) cycle.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high
//   bus   - seq_pattern_gen_if.slave: start, pattern, [repeat_cnt] in;
//           out, out_valid, busy, done out (all registered)
// Optional feature: SEQ_GEN_REPEAT_EN -- frame is sent repeat_cnt+1 times
// with GAP_BITS idle cycles between frames; done only after the last one.
module seq_pattern_gen #(
  parameter int PATTERN_LEN = 7,
  parameter int GAP_BITS    = 2,
  parameter int REPEAT_W    = 4
) (
  input  logic            clk,
  input  logic            reset,
  seq_pattern_gen_if.slave bus
);
  localparam int              CW       = $clog2(PATTERN_LEN);
  localparam logic [CW-1:0]   BIT_LAST = CW'(PATTERN_LEN - 1);

`ifdef SEQ_GEN_REPEAT_EN
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  localparam int              GW       = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [GW-1:0]   GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t                 state_q, state_d;
  logic [PATTERN_LEN-1:0] sh_q, sh_d;      // bits still to send, next at MSB
  logic [CW-1:0]          cnt_q, cnt_d;    // index of bit currently on out
  logic                   out_q, out_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
`ifdef SEQ_GEN_REPEAT_EN
  logic [PATTERN_LEN-1:0] pat_q, pat_d;    // original word, reloaded per frame
  logic [REPEAT_W-1:0]    rpt_q, rpt_d;    // frames left after the current one
  logic [GW-1:0]          gap_q, gap_d;
`endif

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SEQ_GEN_REPEAT_EN
    pat_d   = pat_q;
    rpt_d   = rpt_q;
    gap_d   = gap_q;
`endif
    case (state_q)
      IDLE: begin
        out_d   = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (bus.start) begin
          // accepting edge already presents the MSB
          sh_d    = bus.pattern << 1;
          out_d   = bus.pattern[PATTERN_LEN-1];
          valid_d = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef SEQ_GEN_REPEAT_EN
          pat_d   = bus.pattern;
          rpt_d   = bus.repeat_cnt;
`endif
        end
      end
      SHIFT: begin
        if (cnt_q == BIT_LAST) begin
          out_d   = 1'b0;
          valid_d = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef SEQ_GEN_REPEAT_EN
          if (rpt_q != '0) begin
            rpt_d  = rpt_q - 1'b1;
            busy_d = 1'b1;
            done_d = 1'b0;
            if (GAP_BITS == 0) begin
              sh_d    = pat_q << 1;
              out_d   = pat_q[PATTERN_LEN-1];
              valid_d = 1'b1;
              state_d = SHIFT;
            end else begin
              gap_d   = '0;
              state_d = GAP;
            end
          end
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
          out_d = sh_q[PATTERN_LEN-1];
          sh_d  = sh_q << 1;
        end
      end
`ifdef SEQ_GEN_REPEAT_EN
      GAP: begin
        if (gap_q == GAP_LAST) begin
          sh_d    = pat_q << 1;
          out_d   = pat_q[PATTERN_LEN-1];
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_GEN_REPEAT_EN
      pat_q   <= '0;
      rpt_q   <= '0;
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SEQ_GEN_REPEAT_EN
      pat_q   <= pat_d;
      rpt_q   <= rpt_d;
      gap_q   <= gap_d;
`endif
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule
